// File: rtl/mix_pkg.sv
// Shared definitions for the lane-serial mixing sequencer: lane geometry,
// phase and FSM state encodings, per-lane multiply/add constants and the
// modulo-8 lane index helper used by the lane ALU.
package mix_pkg;

    localparam int LANES  = 8;
    localparam int LANE_W = 32;

    typedef logic [LANES-1:0][LANE_W-1:0] lanes_t;

    typedef enum logic [2:0] {
        PH_ADD   = 3'd0,
        PH_CHAIN = 3'd1,
        PH_XSH   = 3'd2,
        PH_SHM   = 3'd3,
        PH_DIFF  = 3'd4,
        PH_MUL   = 3'd5
    } phase_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Element i is the constant for lane i (lane 0 is the rightmost entry).
    localparam logic [LANES-1:0][4:0] K_TAB = {5'd19, 5'd17, 5'd13, 5'd11, 5'd7, 5'd5, 5'd3, 5'd2};
    localparam logic [LANES-1:0][4:0] C_TAB = {5'd23, 5'd19, 5'd17, 5'd13, 5'd11, 5'd7, 5'd5, 5'd3};

    // Lane indices are 3 bits wide, so plain addition wraps modulo 8.
    // Subtracting n is expressed as adding (8 - n).
    function automatic logic [2:0] lane_wrap(input logic [2:0] lane, input logic [2:0] offset);
        return lane + offset;
    endfunction

endpackage

// File: rtl/mix_lane_alu.sv
// Combinational lane ALU shared by every phase: computes the new value of one
// lane from the current register contents of all eight lanes.
module mix_lane_alu
    import mix_pkg::*;
(
    input  phase_e              phase,
    input  logic [2:0]          lane,
    input  lanes_t              o,
    output logic [LANE_W-1:0]   result
);

    logic [LANE_W-1:0] cur;
    logic [LANE_W-1:0] prev1;
    logic [LANE_W-1:0] prev2;
    logic [LANE_W-1:0] next2;
    logic [LANE_W-1:0] next3;
    logic [LANE_W-1:0] next4;

    assign cur   = o[lane];
    assign prev1 = o[lane_wrap(lane, 3'd7)];
    assign prev2 = o[lane_wrap(lane, 3'd6)];
    assign next2 = o[lane_wrap(lane, 3'd2)];
    assign next3 = o[lane_wrap(lane, 3'd3)];
    assign next4 = o[lane_wrap(lane, 3'd4)];

    // Select the phase operation; the multiply is a 32x5 constant product truncated to 32 bits.
    always_comb begin
        result = cur;
        case (phase)
            PH_ADD:   result = cur + LANE_W'(lane);
            PH_CHAIN: result = cur + prev1;
            PH_XSH:   result = cur ^ (next3 << 16);
            PH_SHM:   result = cur - (next2 >> 17) + (next4 >> 12);
            PH_DIFF:  result = cur + prev1 - prev2;
            PH_MUL:   result = (cur * LANE_W'(K_TAB[lane])) + LANE_W'(C_TAB[lane]);
            default:  result = cur;
        endcase
    end

endmodule

// File: rtl/mix_round_sequencer.sv
// Lane-serial mixing sequencer: accepts a 256-bit seed, runs ROUNDS rounds of
// six phases with one lane update per cycle through a shared lane ALU, then
// presents the result on a valid/ready handshake.
// Optional feature macro: MIX_ABORT_EN adds an 'abort' input that returns the
// sequencer to IDLE from RUN or DONE on the next edge.
module mix_round_sequencer
    import mix_pkg::*;
#(
    parameter int ROUNDS = 2,
    parameter int RND_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
`ifdef MIX_ABORT_EN
    input  logic                     abort,
`endif
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [LANES*LANE_W-1:0]  in_state,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*LANE_W-1:0]  out_state,
    output logic                     busy,
    output logic [2:0]               cur_phase,
    output logic [2:0]               cur_lane,
    output logic [RND_W-1:0]         cur_round
);

    if (ROUNDS < 1) begin : g_rounds_too_small
        $error("mix_round_sequencer: ROUNDS must be at least 1");
    end
    if (ROUNDS > (1 << RND_W) - 1) begin : g_rounds_too_large
        $error("mix_round_sequencer: ROUNDS does not fit in RND_W bits");
    end

    state_e            state;
    lanes_t            o;
    lanes_t            o_next;
    phase_e            phase;
    logic [2:0]        lane;
    logic [RND_W-1:0]  round;
    logic [RND_W-1:0]  round_inc;
    logic [LANE_W-1:0] alu_result;
    logic              last_lane;
    logic              last_phase;
    logic              last_round;
    logic              abort_req;

`ifdef MIX_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_lane  = (lane == 3'd7);
    assign last_phase = (phase == PH_MUL);
    assign round_inc  = round + RND_W'(1);
    assign last_round = (round_inc == RND_W'(ROUNDS));

    assign cur_phase = phase;
    assign cur_lane  = lane;
    assign cur_round = round;

    mix_lane_alu u_alu (
        .phase  (phase),
        .lane   (lane),
        .o      (o),
        .result (alu_result)
    );

    // Lane vector with the currently addressed lane replaced by the ALU result.
    always_comb begin
        o_next       = o;
        o_next[lane] = alu_result;
    end

    // Sequencer FSM: seed capture, lane/phase/round stepping and result handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            o         <= '0;
            phase     <= PH_ADD;
            lane      <= '0;
            round     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_state <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        o        <= in_state;
                        phase    <= PH_ADD;
                        lane     <= '0;
                        round    <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort_req) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        in_ready <= 1'b1;
                    end else begin
                        o    <= o_next;
                        lane <= lane + 3'd1;
                        if (last_lane) begin
                            if (last_phase) begin
                                phase <= PH_ADD;
                                round <= round_inc;
                                if (last_round) begin
                                    state     <= DONE;
                                    busy      <= 1'b0;
                                    out_valid <= 1'b1;
                                    out_state <= o_next;
                                end
                            end else begin
                                phase <= phase_e'(phase + 3'd1);
                            end
                        end
                    end
                end
                DONE: begin
                    if (abort_req || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mix_round_sequencer.sv
// Self-checking bench for mix_round_sequencer. A behavioural reference computes
// each job's result from the phase rules and tracks the expected handshake and
// progress counters; a compare process checks the DUT on every falling edge.
module tb_mix_round_sequencer;

    localparam int ROUNDS    = 2;
    localparam int RND_W     = 8;
    localparam int JOB_STEPS = 48 * ROUNDS;

    logic             clk       = 1'b0;
    logic             rst_n     = 1'b0;
    logic             in_valid  = 1'b0;
    logic             out_ready = 1'b0;
    logic [255:0]     in_state  = '0;
    logic             in_ready;
    logic             out_valid;
    logic             busy;
    logic [255:0]     out_state;
    logic [2:0]       cur_phase;
    logic [2:0]       cur_lane;
    logic [RND_W-1:0] cur_round;
    logic             abortNow;
`ifdef MIX_ABORT_EN
    logic             abort = 1'b0;
    assign abortNow = abort;
`else
    assign abortNow = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference state: mode 0 = idle, 1 = running, 2 = result presented.
    int           mMode = 0;
    int           mStep = 0;
    int           cycle = 0;
    int           numAccepts = 0;
    int           lastAccept = 0;
    int           prevAccept = 0;
    int           lastHandshake = 0;
    logic [255:0] mExpect = '0;

    int kTab [8] = '{2, 3, 5, 7, 11, 13, 17, 19};
    int cTab [8] = '{3, 5, 7, 11, 13, 17, 19, 23};

    always #5 clk = ~clk;

    mix_round_sequencer #(
        .ROUNDS (ROUNDS),
        .RND_W  (RND_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef MIX_ABORT_EN
        .abort     (abort),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy),
        .cur_phase (cur_phase),
        .cur_lane  (cur_lane),
        .cur_round (cur_round)
    );

    // Golden model: apply the first nsteps lane updates in order to a seed.
    function automatic logic [255:0] modelSteps(input logic [255:0] seed, input int nsteps);
        logic [31:0]  o [8];
        logic [255:0] r;
        for (int i = 0; i < 8; i++) o[i] = seed[32*i +: 32];
        for (int s = 0; s < nsteps; s++) begin
            int ph;
            int i;
            ph = (s / 8) % 6;
            i  = s % 8;
            case (ph)
                0: o[i] = o[i] + 32'(i);
                1: o[i] = o[i] + o[(i + 7) % 8];
                2: o[i] = o[i] ^ (o[(i + 3) % 8] << 16);
                3: o[i] = o[i] - (o[(i + 2) % 8] >> 17) + (o[(i + 4) % 8] >> 12);
                4: o[i] = o[i] + o[(i + 7) % 8] - o[(i + 6) % 8];
                default: o[i] = o[i] * 32'(kTab[i]) + 32'(cTab[i]);
            endcase
        end
        for (int i = 0; i < 8; i++) r[32*i +: 32] = o[i];
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [255:0] actual, input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got timeout, want event within bound", name);
    endtask

    // Cycle-level reference of the handshake and job progress.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mMode = 0;
            mStep = 0;
        end else begin
            cycle++;
            case (mMode)
                0: if (in_valid) begin
                    mMode      = 1;
                    mStep      = 0;
                    mExpect    = modelSteps(in_state, JOB_STEPS);
                    prevAccept = lastAccept;
                    lastAccept = cycle;
                    numAccepts++;
                end
                1: if (abortNow) begin
                    mMode = 0;
                end else begin
                    mStep++;
                    if (mStep == JOB_STEPS) mMode = 2;
                end
                default: if (abortNow) begin
                    mMode = 0;
                end else if (out_ready) begin
                    mMode         = 0;
                    lastHandshake = cycle;
                end
            endcase
        end
    end

    // Compare DUT outputs against the reference away from the active edge.
    always @(negedge clk) begin
        checkOutput("in_ready", 256'(in_ready), 256'(mMode == 0));
        checkOutput("busy", 256'(busy), 256'(mMode == 1));
        checkOutput("out_valid", 256'(out_valid), 256'(mMode == 2));
        if (mMode == 1) begin
            checkOutput("cur_round", 256'(cur_round), 256'(mStep / 48));
            checkOutput("cur_phase", 256'(cur_phase), 256'((mStep % 48) / 8));
            checkOutput("cur_lane", 256'(cur_lane), 256'(mStep % 8));
        end
        if (mMode == 2) begin
            checkOutput("out_state", out_state, mExpect);
            checkOutput("done_round", 256'(cur_round), 256'(ROUNDS));
        end
    end

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_in_ready"}, 256'(in_ready), 256'(1));
        checkOutput({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
        checkOutput({tag, "_out_state"}, out_state, 256'(0));
        checkOutput({tag, "_cur_phase"}, 256'(cur_phase), 256'(0));
        checkOutput({tag, "_cur_lane"}, 256'(cur_lane), 256'(0));
        checkOutput({tag, "_cur_round"}, 256'(cur_round), 256'(0));
    endtask

    // Hand-computed values that pin the golden model itself.
    task automatic pinModel();
        logic [255:0] r;
        r = modelSteps('0, 16);
        checkOutput("model_chain_l0", 256'(r[31:0]), 256'(32'd7));
        checkOutput("model_chain_l3", 256'(r[127:96]), 256'(32'd13));
        checkOutput("model_chain_l7", 256'(r[255:224]), 256'(32'd35));
        r = modelSteps('0, 17);
        checkOutput("model_xsh_l0", 256'(r[31:0]), 256'(32'h000D_0007));
        r = modelSteps({256{1'b1}}, 8);
        checkOutput("model_wrap_l1", 256'(r[63:32]), 256'(32'd0));
        checkOutput("model_wrap_l7", 256'(r[255:224]), 256'(32'd6));
    endtask

    // Present a seed and hold it until the reference sees it accepted.
    task automatic applyStimulus(input logic [255:0] seed);
        int n0;
        int n;
        @(negedge clk);
        n0       = numAccepts;
        in_state = seed;
        in_valid = 1'b1;
        n        = 0;
        while (numAccepts == n0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (numAccepts == n0) reportTimeout("accept");
        else checkOutput("accept_busy", 256'(busy), 256'(1));
    endtask

    task automatic waitOutValid(input string name, output int riseCycle);
        int n;
        n         = 0;
        riseCycle = -1;
        while (out_valid !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (out_valid === 1'b1) riseCycle = cycle;
        else reportTimeout(name);
    endtask

    initial begin
        int           rise;
        int           n;
        int           n0;
        logic [255:0] onesResult;

        pinModel();

        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checkResetValues("por");
        rst_n = 1'b1;

        // Zero seed, consumer always ready: latency counted from accept cycle
        out_ready = 1'b1;
        applyStimulus('0);
        waitOutValid("job_zero_done", rise);
        checkOutput("latency", 256'(rise - lastAccept + 1), 256'(JOB_STEPS + 1));
        checkOutput("zero_result", out_state, modelSteps('0, JOB_STEPS));
        repeat (2) @(negedge clk);

        // All-ones seed, consumer stalls 20 cycles while a new seed is offered
        out_ready = 1'b0;
        applyStimulus({256{1'b1}});
        waitOutValid("job_ones_done", rise);
        onesResult = modelSteps({256{1'b1}}, JOB_STEPS);
        in_state   = {8{32'h1234_5678}};
        in_valid   = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", 256'(out_valid), 256'(1));
            checkOutput("stall_state", out_state, onesResult);
            checkOutput("stall_in_ready", 256'(in_ready), 256'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release_idle", 256'(in_ready), 256'(1));
        checkOutput("release_not_busy", 256'(busy), 256'(0));
        repeat (2) @(negedge clk);

        // Back-to-back jobs with the seed held and the consumer always ready
        in_state = {32'h8000_0001, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 32'h0000_FFFF,
                    32'hFFFF_0000, 32'h0F0F_0F0F, 32'h1357_9BDF, 32'h0000_0001};
        n0       = numAccepts;
        in_valid = 1'b1;
        n        = 0;
        while (numAccepts < n0 + 2 && n < 400) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        if (numAccepts < n0 + 2) begin
            reportTimeout("back_to_back");
        end else begin
            checkOutput("b2b_period", 256'(lastAccept - prevAccept), 256'(JOB_STEPS + 2));
            checkOutput("b2b_after_handshake", 256'(lastAccept - lastHandshake), 256'(1));
        end
        waitOutValid("b2b_done", rise);
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of a job
        applyStimulus({8{32'hA5A5_5A5A}});
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midrun_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        applyStimulus({8{32'h0000_0003}});
        waitOutValid("post_reset_done", rise);
        checkOutput("post_reset_result", out_state, modelSteps({8{32'h0000_0003}}, JOB_STEPS));
        repeat (2) @(negedge clk);

`ifdef MIX_ABORT_EN
        // Abort part-way through a job, then run a fresh job
        out_ready = 1'b1;
        applyStimulus({8{32'hCAFE_F00D}});
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("abort_idle", 256'(in_ready), 256'(1));
        checkOutput("abort_no_valid", 256'(out_valid), 256'(0));
        checkOutput("abort_not_busy", 256'(busy), 256'(0));
        for (int i = 0; i < JOB_STEPS + 10; i++) begin
            @(negedge clk);
            checkOutput("abort_quiet", 256'(out_valid), 256'(0));
        end
        applyStimulus({8{32'h0BAD_CAFE}});
        waitOutValid("post_abort_done", rise);
        checkOutput("post_abort_result", out_state, modelSteps({8{32'h0BAD_CAFE}}, JOB_STEPS));
        repeat (2) @(negedge clk);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, want end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
